alu_share_arbiter: RTL

// Shares one combinational ALU between two requesters, e.g. the execute stage and an address/branch helper.

---
 rtl/alu_share_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters with round-robin/lock arbitration
// and per-requester response registers. Define ALU_ARB_STATS_EN to build the grant/conflict counters.
module alu_share_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [7:0]           req_func,
    input  logic [5:0]           req_aluop,
    input  logic [1:0]           req_lock,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic [1:0]           rsp_branch,
    output logic [WIDTH-1:0]     alu_dataA,
    output logic [WIDTH-1:0]     alu_dataB,
    output logic [3:0]           alu_func,
    output logic [2:0]           alu_aluOp,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_branch,
    output logic [15:0]          stat_grant0,
    output logic [15:0]          stat_grant1,
    output logic [15:0]          stat_conflict
);

    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    localparam logic [1:0] ST_RR    = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [1:0]         rsp_branch_q, rsp_branch_d;

    logic [1:0] eligible_c;
    logic [1:0] grant_c;
    logic       gidx_c;
    logic       conflict_c;

    // A full slot being drained this cycle counts as free; nothing is granted while in reset.
    always_comb begin
        eligible_c = req_valid & (~rsp_valid_q | rsp_ready);
        grant_c    = 2'b00;
        if (rst_n) begin
            case (state_q)
                ST_LOCK0: grant_c = {1'b0, eligible_c[0]};
                ST_LOCK1: grant_c = {eligible_c[1], 1'b0};
                default: begin
                    if (&eligible_c) begin
                        grant_c = rr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_c = eligible_c;
                    end
                end
            endcase
        end
    end

    assign gidx_c     = grant_c[1];
    assign conflict_c = (state_q == ST_RR) && (&eligible_c);
    assign req_ready  = grant_c;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_LOCK0, ST_LOCK1: begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                if ((|grant_c) && !req_lock[gidx_c]) begin
                    state_d    = ST_RR;
                    lock_cnt_d = '0;
                end
                // Forced release overrides whatever was granted this cycle.
                if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ST_RR;
                    rr_d       = (state_q == ST_LOCK0);
                    lock_cnt_d = '0;
                end
            end
            default: begin
                if (|grant_c) begin
                    rr_d = ~gidx_c;
                    if (req_lock[gidx_c]) begin
                        state_d    = gidx_c ? ST_LOCK1 : ST_LOCK0;
                        lock_cnt_d = '0;
                    end
                end
            end
        endcase
    end

    // ALU operand mux; idle ALU sees all-zero inputs.
    always_comb begin
        alu_dataA = '0;
        alu_dataB = '0;
        alu_func  = 4'h0;
        alu_aluOp = 3'h0;
        if (grant_c[0]) begin
            alu_dataA = req_a[0 +: WIDTH];
            alu_dataB = req_b[0 +: WIDTH];
            alu_func  = req_func[0 +: 4];
            alu_aluOp = req_aluop[0 +: 3];
        end else if (grant_c[1]) begin
            alu_dataA = req_a[WIDTH +: WIDTH];
            alu_dataB = req_b[WIDTH +: WIDTH];
            alu_func  = req_func[4 +: 4];
            alu_aluOp = req_aluop[3 +: 3];
        end
    end

    always_comb begin
        rsp_valid_d  = (rsp_valid_q & ~rsp_ready) | grant_c;
        rsp_result_d = rsp_result_q;
        rsp_branch_d = rsp_branch_q;
        if (grant_c[0]) begin
            rsp_result_d[0 +: WIDTH] = alu_result;
            rsp_branch_d[0]          = alu_branch;
        end
        if (grant_c[1]) begin
            rsp_result_d[WIDTH +: WIDTH] = alu_result;
            rsp_branch_d[1]              = alu_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RR;
            rr_q         <= 1'b0;
            lock_cnt_q   <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_branch_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            lock_cnt_q   <= lock_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_branch_q <= rsp_branch_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;
    logic [15:0] stat_conflict_q, stat_conflict_d;

    // Saturating event counters.
    always_comb begin
        stat_grant0_d   = stat_grant0_q;
        stat_grant1_d   = stat_grant1_q;
        stat_conflict_d = stat_conflict_q;
        if (grant_c[0] && (stat_grant0_q != 16'hFFFF)) begin
            stat_grant0_d = stat_grant0_q + 16'd1;
        end
        if (grant_c[1] && (stat_grant1_q != 16'hFFFF)) begin
            stat_grant1_d = stat_grant1_q + 16'd1;
        end
        if (conflict_c && (stat_conflict_q != 16'hFFFF)) begin
            stat_conflict_d = stat_conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q   <= 16'h0;
            stat_grant1_q   <= 16'h0;
            stat_conflict_q <= 16'h0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`else
    logic unused_conflict;
    assign unused_conflict = conflict_c;
    assign stat_grant0     = 16'h0;
    assign stat_grant1     = 16'h0;
    assign stat_conflict   = 16'h0;
`endif

endmodule
